// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: reset PC, bubble instruction,
// branch opcodes and the IF->ID bundle layout.
package pipe_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] NOP_INST = 32'h03400000;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BNE  = 6'h17;

  localparam int IF_TO_ID_W = 65;
  localparam int PRED_BIT   = 64;
  localparam int INST_LSB   = 32;
  localparam int PC_LSB     = 0;

  typedef struct packed {
    logic        predict;
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

  function automatic logic [5:0] opcode(
    input logic [31:0] inst
  );
    return inst[31:26];
  endfunction

endpackage

// File: rtl/if_bpred.sv
// Static branch predictor: b/bl always taken, beq/bne backward-taken.
// Ports: fs_inst, fs_pc, en in; pred_taken, pred_target out.
module if_bpred
  import pipe_pkg::*;
#(
  parameter bit BTFN_EN = 1'b1
) (
  input  logic [31:0] fs_inst,
  input  logic [31:0] fs_pc,
  input  logic        en,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [5:0]  op;
  logic [31:0] offs26;
  logic [31:0] offs16;
  logic        is_jmp;
  logic        is_bcc;

  assign op = opcode(fs_inst);

  // b/bl: 26-bit word offset split as {inst[9:0], inst[25:10]}
  assign offs26 = {{4{fs_inst[9]}},
                   fs_inst[9:0],
                   fs_inst[25:10],
                   2'b00};

  assign offs16 = {{14{fs_inst[25]}},
                   fs_inst[25:10],
                   2'b00};

  assign is_jmp = en &
                  ((op == OP_B) |
                   (op == OP_BL));

  assign is_bcc = en &
                  ((op == OP_BEQ) |
                   (op == OP_BNE));

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = fs_pc + 32'd4;
    unique case (1'b1)
      is_jmp: begin
        pred_taken  = 1'b1;
        pred_target = fs_pc + offs26;
      end
      is_bcc: begin
        // sign bit of the offset: backward branch
        pred_taken  = BTFN_EN & fs_inst[25];
        pred_target = fs_pc + offs16;
      end
      default: begin
        pred_taken  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, skid buffer, nextpc mux, IF->ID bundle.
// Ports: clk, rst, ID_allowin, flush, pc_real, inst_sram_*, IF_to_ID_zip.
module if_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST,
  parameter bit          BTFN_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_allowin,
  input  logic        flush,
  input  logic [31:0] pc_real,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic [64:0] IF_to_ID_zip
);

  import pipe_pkg::*;

  localparam logic [31:0] PC_INIT =
    RESET_PC - 32'd4;

  logic [31:0] fs_pc;
  logic        fs_valid;
  logic        buf_valid;
  logic [31:0] inst_buf;

  logic [31:0] fs_inst;
  logic [31:0] nextpc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        advance;
  if_id_t      zip;

  // while stalled, the SRAM output is not held: use the skid copy
  assign fs_inst = buf_valid ? inst_buf
                             : inst_sram_rdata;

  if_bpred #(
    .BTFN_EN(BTFN_EN)
  ) u_bpred (
    .fs_inst    (fs_inst),
    .fs_pc      (fs_pc),
    .en         (fs_valid),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  always_comb begin
    nextpc = fs_pc + 32'd4;
    if (flush)
      nextpc = pc_real;
    else if (pred_taken)
      nextpc = pred_target;
  end

  // flush fetches even when ID is stalled
  assign advance = flush | ID_allowin;

  assign inst_sram_en    = ~rst & advance;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

  always_comb begin
    zip.predict = 1'b0;
    zip.inst    = NOP_INST;
    zip.pc      = fs_pc;
    if (rst) begin
      zip.pc = PC_INIT;
    end else if (fs_valid) begin
      zip.predict = pred_taken;
      zip.inst    = fs_inst;
    end
  end

  assign IF_to_ID_zip = zip;

  always_ff @(posedge clk) begin
    if (rst) begin
      fs_pc     <= PC_INIT;
      fs_valid  <= 1'b0;
      buf_valid <= 1'b0;
      inst_buf  <= 32'b0;
    end else if (advance) begin
      fs_pc     <= nextpc;
      fs_valid  <= 1'b1;
      buf_valid <= 1'b0;
    end else if (fs_valid & ~buf_valid) begin
      // first stall cycle: rdata is still the fetched word
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a program-level fetch model.
// The model tracks only the presented PC; instructions come from mem().
module tb_if_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_allowin;
  logic        flush;
  logic [31:0] pc_real;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [64:0] IF_to_ID_zip;

  always #5 clk = ~clk;

  if_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .ID_allowin     (ID_allowin),
    .flush          (flush),
    .pc_real        (pc_real),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .IF_to_ID_zip   (IF_to_ID_zip)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(
    input string       tag,
    input logic [64:0] got,
    input logic [64:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
  endtask

  bit          directed;
  bit          req_en;
  logic [31:0] req_addr;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] last_addr;
  logic [64:0] last_zip;

  function automatic logic [31:0] mem(
    input logic [31:0] a
  );
    logic [31:0] h;
    if (directed) begin
      if (a == 32'h1c000010) return 32'h50001000;
      if (a == 32'h1c000020) return 32'h5BFFFC00;
      return 32'h28000000 ^ {10'h0, a[21:0]};
    end
    h = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0:    return {6'h14, h[25:0]};
      3'd1:    return {6'h15, h[25:0]};
      3'd2:    return {6'h16, h[25:0]};
      3'd3:    return {6'h17, h[25:0]};
      3'd4:    return {6'h13, h[25:0]};
      default: return {6'h0a, a[25:0]};
    endcase
  endfunction

  // {taken, target} from the ISA rules, signed offsets in plain ints
  function automatic logic [32:0] ref_pred(
    input logic [31:0] inst,
    input logic [31:0] pc
  );
    int op;
    int off;
    op = int'(inst[31:26]);
    if (op == 'h14 || op == 'h15) begin
      off = int'({inst[9:0], inst[25:10]});
      if (off >= (1 << 25)) off = off - (1 << 26);
      return {1'b1, pc + 32'(off * 4)};
    end
    if (op == 'h16 || op == 'h17) begin
      off = int'(inst[25:10]);
      if (off >= (1 << 15)) off = off - (1 << 16);
      if (off < 0)
        return {1'b1, pc + 32'(off * 4)};
    end
    return {1'b0, pc + 32'd4};
  endfunction

  task automatic cyc(
    input bit          r,
    input bit          a,
    input bit          f,
    input logic [31:0] pr
  );
    logic [32:0] p;
    logic [31:0] npc;
    logic [64:0] ez;
    bit          een;
    rst        = r;
    ID_allowin = a;
    flush      = f;
    pc_real    = pr;
    inst_sram_rdata = req_en ? mem(req_addr)
                             : $urandom;
    #1;
    p = ref_pred(mem(m_pc), m_pc);
    if (r)
      ez = {1'b0, NOP_INST, RESET_PC - 32'd4};
    else if (m_valid)
      ez = {p[32], mem(m_pc), m_pc};
    else
      ez = {1'b0, NOP_INST, m_pc};
    if (f)
      npc = pr;
    else if (m_valid && p[32])
      npc = p[31:0];
    else
      npc = m_pc + 32'd4;
    een = !r && (f || a);
    chk("en", 65'(inst_sram_en), 65'(een));
    if (een)
      chk("addr", 65'(inst_sram_addr), 65'(npc));
    chk("zip", IF_to_ID_zip, ez);
    chk("we_wdata",
        65'({inst_sram_we, inst_sram_wdata}),
        65'(0));
    last_addr = inst_sram_addr;
    last_zip  = IF_to_ID_zip;
    req_en    = inst_sram_en;
    req_addr  = inst_sram_addr;
    if (r) begin
      m_pc    = RESET_PC - 32'd4;
      m_valid = 1'b0;
    end else if (f || a) begin
      m_pc    = npc;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          rr;
    bit          aa;
    bit          ff;
    logic [31:0] pr;
    directed = 1'b1;
    req_en   = 1'b0;
    req_addr = 32'h0;
    m_pc     = RESET_PC - 32'd4;
    m_valid  = 1'b0;

    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t1_addr", 65'(last_addr), 65'(32'h1c000000));
    chk("t1_zip0", last_zip,
        {1'b0, 32'h03400000, 32'h1bfffffc});
    cyc(0, 1, 0, 0);
    chk("t1_zip1", last_zip,
        {1'b0, 32'h28000000, 32'h1c000000});
    cyc(0, 1, 0, 0);
    chk("t2_addr", 65'(last_addr), 65'(32'h1c000008));

    repeat (3) cyc(0, 0, 0, 0);
    chk("t3_hold", last_zip,
        {1'b0, 32'h28000008, 32'h1c000008});
    cyc(0, 1, 0, 0);
    chk("t3_rel", 65'(last_addr), 65'(32'h1c00000c));
    cyc(0, 1, 0, 0);
    chk("t3_once", 65'(last_zip[31:0]),
        65'(32'h1c00000c));

    cyc(0, 1, 0, 0);
    chk("t4_pred", 65'(last_zip[64]), 65'(1));
    chk("t4_addr", 65'(last_addr), 65'(32'h1c000020));
    cyc(0, 1, 0, 0);
    chk("t5_pred", 65'(last_zip[64]), 65'(1));
    chk("t5_addr", 65'(last_addr), 65'(32'h1c00001c));
    cyc(0, 1, 0, 0);

    repeat (2) begin
      cyc(0, 0, 1, 32'h1c000100);
      chk("t6_addr", 65'(last_addr),
          65'(32'h1c000100));
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t6_zip", last_zip,
        {1'b0, 32'h28000100, 32'h1c000100});
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t6_rst", last_zip,
        {1'b0, 32'h03400000, 32'h1bfffffc});

    directed = 1'b0;
    repeat (3000) begin
      rr = ($urandom % 64) == 0;
      aa = ($urandom % 10) < 7;
      ff = ($urandom % 10) == 0;
      pr = RESET_PC +
           {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cyc(rr, aa, ff, pr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
